// File: rtl/seg_pkg.sv
// Shared constants for the segment scan display stage:
// blank pattern, active-low hex glyph table and lookup helper.
package seg_pkg;

    // All segments off ({g,f,e,d,c,b,a}, active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Glyph table, entry [v] is the pattern for hex value v.
    localparam logic [15:0][6:0] HEX7_TAB = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] hex7(input logic [3:0] v);
        return HEX7_TAB[v];
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bundle between the counter chain (master) and the display
// scanner (slave): counter values and controls in, pins out.
interface seg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] digits_in;
    logic                co_in;
    logic                hold;
    logic                blank_lz;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic                dp;

    modport master (
        output digits_in, co_in, hold, blank_lz,
        input  seg, an, dp
    );

    modport slave (
        input  digits_in, co_in, hold, blank_lz,
        output seg, an, dp
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-low 7-segment pattern.
// Instanced once on the currently scanned digit.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex7(d_i);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scanner for a cascaded counter chain:
// frame-latched snapshot, leading-zero blanking, stretched overflow dp.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int STRETCH  = 25000000
) (
    input  logic            clk,
    input  logic            mr,
    seg_scan_driver_if.slave bus
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW = $clog2(STRETCH + 1);

    localparam logic [PW-1:0] PSC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [SW-1:0] CNT_LOAD = SW'(STRETCH);

    logic [PW-1:0]         psc_q, psc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   snap_q, snap_d;
    logic [SW-1:0]         cnt_q, cnt_d;
    logic                  co_q, co_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  tick;
    logic                  rise;
    logic                  upper_zero;
    logic                  blank;
    logic [3:0]            cur_dig;
    logic [6:0]            dec_seg;

    assign tick = (psc_q == PSC_LAST);
    assign rise = bus.co_in & ~co_q;

    // Select the scanned digit and find whether it and all above are zero.
    always_comb begin
        cur_dig    = 4'h0;
        upper_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (IW'(j) == idx_q)
                cur_dig = snap_q[4*j +: 4];
            if (IW'(j) >= idx_q && snap_q[4*j +: 4] != 4'h0)
                upper_zero = 1'b0;
        end
    end

    assign blank = bus.blank_lz && (idx_q != '0) && upper_zero;

    seg7_decode u_dec (
        .d_i   (cur_dig),
        .seg_o (dec_seg)
    );

    // Next-state: prescaler, digit index, frame snapshot, stretch, outputs.
    always_comb begin
        psc_d  = tick ? '0 : psc_q + 1'b1;
        idx_d  = idx_q;
        snap_d = snap_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            if (idx_q == IDX_LAST && !bus.hold)
                snap_d = bus.digits_in;
        end
        co_d = bus.co_in;
        if (rise)
            cnt_d = CNT_LOAD;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
        else
            cnt_d = cnt_q;
        an_d  = ~(DIGITS'(1) << idx_q);
        seg_d = blank ? SEG_BLANK : dec_seg;
        dp_d  = ~((cnt_q != '0) && (idx_q == '0));
    end

    // State and registered pins, synchronous reset dominates.
    always_ff @(posedge clk) begin
        if (mr) begin
            psc_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            cnt_q  <= '0;
            co_q   <= 1'b0;
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            psc_q  <= psc_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            cnt_q  <= cnt_d;
            co_q   <= co_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule
